// File: rtl/mm_bus_pkg.sv
// Shared types and constants for the two-master memory-mapped bus arbiter.
package mm_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int unsigned M0    = 0;
  localparam int unsigned M1    = 1;
  localparam int unsigned CNT_W = 8;

  // Read data returned to a master whose transaction timed out.
  localparam logic [63:0] ERR_RDATA = '0;

endpackage

// File: rtl/mm_bus_arbiter_rr.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered pointer.
module rr_arbiter2
  import mm_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant_c
);

  // 0 favours M0, 1 favours M1.
  logic ptr_q;

  // Pick a master; the pointer only matters when both are requesting.
  always_comb begin
    grant_c = 2'b00;
    if (advance) begin
      if (req == 2'b11) begin
        grant_c[M0] = ~ptr_q;
        grant_c[M1] = ptr_q;
      end else begin
        grant_c = req;
      end
    end
  end

  // Hand priority to the loser after each contended grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (advance && (req == 2'b11)) begin
      ptr_q <= ~ptr_q;
    end
  end

endmodule

// File: rtl/mm_bus_arbiter.sv
// Shares one memory-mapped peripheral port between two masters, with a
// bounded wait on the peripheral OK and an error response on timeout.
module mm_bus_arbiter
  import mm_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              CoreClock,
  input  logic              Reset,
  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [ADDR_W-1:0] AddressBus,
  output logic [DATA_W-1:0] DataWriteBus,
  input  logic [DATA_W-1:0] DataReadBus,
  output logic              WriteAssert,
  output logic              ReadAssert,
  input  logic              WriteOK,
  input  logic              ReadOK
);

  state_t            state_q, state_d;
  logic [1:0]        grant_c;
  logic              advance_c;
  logic              gnt_q, gnt_d;     // granted master index (M1 when set)
  logic              wr_q, wr_d;       // latched direction of the transaction
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ok_c, tmo_c, take_c, done_c;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d, rdata0_d, rdata1_d, rd_val_c;
  logic              write_assert_d, read_assert_d;
  logic [1:0]        ack_d, err_d;

  assign advance_c = (state_q == IDLE);

  rr_arbiter2 u_arb (
    .clk     (CoreClock),
    .rst     (Reset),
    .req     ({m1_req, m0_req}),
    .advance (advance_c),
    .grant_c (grant_c)
  );

  // Transaction events: grant taken, peripheral OK, timeout reached.
  always_comb begin
    ok_c   = wr_q ? WriteOK : ReadOK;
    tmo_c  = !ok_c && (cnt_q == CNT_W'(TIMEOUT - 1));
    take_c = (state_q == IDLE) && (|grant_c);
    done_c = (state_q == ACCESS) && (ok_c || tmo_c);
  end

  // State register.
  always_ff @(posedge CoreClock) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take_c) state_d = ACCESS;
      ACCESS:  if (done_c) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the latched payload and of every registered output.
  always_comb begin
    gnt_d          = gnt_q;
    wr_d           = wr_q;
    cnt_d          = cnt_q;
    addr_d         = AddressBus;
    wdata_d        = DataWriteBus;
    write_assert_d = WriteAssert;
    read_assert_d  = ReadAssert;
    ack_d          = 2'b00;
    err_d          = 2'b00;
    rdata0_d       = m0_rdata;
    rdata1_d       = m1_rdata;
    rd_val_c       = tmo_c ? DATA_W'(ERR_RDATA) : DataReadBus;
    unique case (state_q)
      IDLE: begin
        if (take_c) begin
          gnt_d          = grant_c[M1];
          wr_d           = gnt_d ? m1_write : m0_write;
          addr_d         = gnt_d ? m1_addr  : m0_addr;
          wdata_d        = gnt_d ? m1_wdata : m0_wdata;
          write_assert_d = wr_d;
          read_assert_d  = !wr_d;
          cnt_d          = '0;
        end
      end
      ACCESS: begin
        if (done_c) begin
          write_assert_d = 1'b0;
          read_assert_d  = 1'b0;
          ack_d[gnt_q]   = 1'b1;
          err_d[gnt_q]   = tmo_c;
          // Writes keep rdata unless they timed out.
          if (tmo_c || !wr_q) begin
            if (gnt_q) rdata1_d = rd_val_c;
            else       rdata0_d = rd_val_c;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        write_assert_d = 1'b0;
        read_assert_d  = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge CoreClock) begin
    if (Reset) begin
      gnt_q        <= 1'b0;
      wr_q         <= 1'b0;
      cnt_q        <= '0;
      AddressBus   <= '0;
      DataWriteBus <= '0;
      WriteAssert  <= 1'b0;
      ReadAssert   <= 1'b0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_err       <= 1'b0;
      m1_err       <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
    end else begin
      gnt_q        <= gnt_d;
      wr_q         <= wr_d;
      cnt_q        <= cnt_d;
      AddressBus   <= addr_d;
      DataWriteBus <= wdata_d;
      WriteAssert  <= write_assert_d;
      ReadAssert   <= read_assert_d;
      m0_ack       <= ack_d[M0];
      m1_ack       <= ack_d[M1];
      m0_err       <= err_d[M0];
      m1_err       <= err_d[M1];
      m0_rdata     <= rdata0_d;
      m1_rdata     <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_mm_bus_arbiter.sv
// Directed bench for mm_bus_arbiter: per-cycle vector table plus
// hand-written timeout, delayed-OK and mid-access reset sequences.
module tb_mm_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          CoreClock = 1'b0;
  logic          Reset;
  logic          m0_req, m0_write, m1_req, m1_write;
  logic [AW-1:0] m0_addr, m1_addr, AddressBus;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic [DW-1:0] DataWriteBus, DataReadBus;
  logic          WriteAssert, ReadAssert, WriteOK, ReadOK;

  mm_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CoreClock(CoreClock), .Reset(Reset),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .AddressBus(AddressBus), .DataWriteBus(DataWriteBus), .DataReadBus(DataReadBus),
    .WriteAssert(WriteAssert), .ReadAssert(ReadAssert),
    .WriteOK(WriteOK), .ReadOK(ReadOK)
  );

  always #5 CoreClock = ~CoreClock;

  typedef struct packed {
    logic          req0, wr0;
    logic [31:0]   addr0, wdata0;
    logic          req1, wr1;
    logic [31:0]   addr1, wdata1;
    logic          rok, wok;
    logic [31:0]   rbus;
  } stim_t;

  typedef struct packed {
    logic          wa, ra, ack0, ack1, err0, err1;
    logic [31:0]   rd0, rd1, addr, wdata;
  } obs_t;

  typedef struct packed {
    stim_t s;
    obs_t  e;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  vec_t vq[$];

  function automatic stim_t mk_s(input logic q0, input logic w0, input logic [31:0] a0,
                                 input logic [31:0] d0, input logic q1, input logic w1,
                                 input logic [31:0] a1, input logic [31:0] d1,
                                 input logic rok, input logic wok, input logic [31:0] rb);
    return '{req0: q0, wr0: w0, addr0: a0, wdata0: d0, req1: q1, wr1: w1,
             addr1: a1, wdata1: d1, rok: rok, wok: wok, rbus: rb};
  endfunction

  function automatic obs_t mk_e(input logic wa, input logic ra, input logic k0,
                                input logic k1, input logic e0, input logic e1,
                                input logic [31:0] r0, input logic [31:0] r1,
                                input logic [31:0] a, input logic [31:0] d);
    return '{wa: wa, ra: ra, ack0: k0, ack1: k1, err0: e0, err1: e1,
             rd0: r0, rd1: r1, addr: a, wdata: d};
  endfunction

  function automatic obs_t sample();
    return '{wa: WriteAssert, ra: ReadAssert, ack0: m0_ack, ack1: m1_ack,
             err0: m0_err, err1: m1_err, rd0: m0_rdata, rd1: m1_rdata,
             addr: AddressBus, wdata: DataWriteBus};
  endfunction

  task automatic apply(input stim_t s);
    m0_req = s.req0; m0_write = s.wr0; m0_addr = s.addr0; m0_wdata = s.wdata0;
    m1_req = s.req1; m1_write = s.wr1; m1_addr = s.addr1; m1_wdata = s.wdata1;
    ReadOK = s.rok;  WriteOK = s.wok;  DataReadBus = s.rbus;
  endtask

  task automatic step();
    @(posedge CoreClock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic chk_obs(input string nm, input obs_t got, input obs_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got wa=%b ra=%b ack=%b%b err=%b%b rd0=%h rd1=%h addr=%h wd=%h | expected wa=%b ra=%b ack=%b%b err=%b%b rd0=%h rd1=%h addr=%h wd=%h",
               nm, got.wa, got.ra, got.ack0, got.ack1, got.err0, got.err1,
               got.rd0, got.rd1, got.addr, got.wdata,
               exp.wa, exp.ra, exp.ack0, exp.ack1, exp.err0, exp.err1,
               exp.rd0, exp.rd1, exp.addr, exp.wdata);
    end
  endtask

  initial begin
    stim_t s_rd0, s_wr1, s_rr, s_off;
    int    n;
    int    stray;

    s_rd0 = mk_s(1, 0, 32'hC, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h2A5);
    s_wr1 = mk_s(0, 0, 32'h0, 32'h0, 1, 1, 32'h4, 32'h3FF, 0, 1, 32'h0);
    s_rr  = mk_s(1, 1, 32'h10, 32'hA0, 1, 0, 32'h20, 32'h77, 1, 1, 32'h55);
    s_off = mk_s(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);

    // Single M0 read.
    vq.push_back({s_rd0, mk_e(0, 1, 0, 0, 0, 0, 32'h0,   32'h0, 32'hC, 32'h0)});
    vq.push_back({s_rd0, mk_e(0, 0, 1, 0, 0, 0, 32'h2A5, 32'h0, 32'hC, 32'h0)});
    vq.push_back({s_off, mk_e(0, 0, 0, 0, 0, 0, 32'h2A5, 32'h0, 32'hC, 32'h0)});
    // Single M1 write.
    vq.push_back({s_wr1, mk_e(1, 0, 0, 0, 0, 0, 32'h2A5, 32'h0, 32'h4, 32'h3FF)});
    vq.push_back({s_wr1, mk_e(0, 0, 0, 1, 0, 0, 32'h2A5, 32'h0, 32'h4, 32'h3FF)});
    vq.push_back({s_off, mk_e(0, 0, 0, 0, 0, 0, 32'h2A5, 32'h0, 32'h4, 32'h3FF)});
    // Continuous contention: M0, M1, M0, M1 with acks 3 cycles apart.
    for (int r = 0; r < 2; r++) begin
      vq.push_back({s_rr, mk_e(1, 0, 0, 0, 0, 0, 32'h2A5, r ? 32'h55 : 32'h0, 32'h10, 32'hA0)});
      vq.push_back({s_rr, mk_e(0, 0, 1, 0, 0, 0, 32'h2A5, r ? 32'h55 : 32'h0, 32'h10, 32'hA0)});
      vq.push_back({s_rr, mk_e(0, 0, 0, 0, 0, 0, 32'h2A5, r ? 32'h55 : 32'h0, 32'h10, 32'hA0)});
      vq.push_back({s_rr, mk_e(0, 1, 0, 0, 0, 0, 32'h2A5, r ? 32'h55 : 32'h0, 32'h20, 32'h77)});
      vq.push_back({s_rr, mk_e(0, 0, 0, 1, 0, 0, 32'h2A5, 32'h55, 32'h20, 32'h77)});
      vq.push_back({r ? s_off : s_rr,
                    mk_e(0, 0, 0, 0, 0, 0, 32'h2A5, 32'h55, 32'h20, 32'h77)});
    end

    apply(s_off);
    Reset = 1'b1;
    step();
    step();
    chk_obs("reset_state", sample(), mk_e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    Reset = 1'b0;

    foreach (vq[i]) begin
      apply(vq[i].s);
      step();
      chk_obs($sformatf("vec%0d", i), sample(), vq[i].e);
    end

    // M0 read that never gets ReadOK: strobe for exactly TIMEOUT cycles, then error.
    apply(mk_s(1, 0, 32'h30, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'hDEAD));
    step();
    n = 0;
    stray = 0;
    for (int i = 0; i < 40 && !m0_ack; i++) begin
      if (ReadAssert) n++;
      if (m1_ack || m1_err || WriteAssert) stray++;
      step();
    end
    chk("timeout_strobe_cycles", 64'(n), 64'(TO));
    chk("timeout_ack", 64'(m0_ack), 64'd1);
    chk("timeout_err", 64'(m0_err), 64'd1);
    chk("timeout_rdata", 64'(m0_rdata), 64'd0);
    chk("timeout_other_master_quiet", 64'(stray), 64'd0);
    apply(s_off);
    step();
    chk("timeout_ack_one_cycle", 64'({m0_ack, m0_err}), 64'd0);

    // M1 read with ReadOK arriving on the sixth ACCESS cycle.
    apply(mk_s(0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0, 0, 0, 32'h1234));
    step();
    n = 0;
    for (int i = 0; i < 40 && !m1_ack; i++) begin
      if (ReadAssert) n++;
      ReadOK = (n >= 6);
      step();
    end
    chk("delayed_strobe_cycles", 64'(n), 64'd6);
    chk("delayed_ack", 64'(m1_ack), 64'd1);
    chk("delayed_err", 64'(m1_err), 64'd0);
    chk("delayed_rdata", 64'(m1_rdata), 64'h1234);
    chk("delayed_m0_quiet", 64'({m0_ack, m0_err}), 64'd0);
    apply(s_off);
    step();

    // Reset in the third ACCESS cycle of a contended grant; pointer must return to M0.
    apply(mk_s(1, 0, 32'h100, 32'h0, 1, 0, 32'h200, 32'h0, 0, 0, 32'hBEEF));
    step();
    step();
    step();
    chk("pre_reset_access", 64'({ReadAssert, AddressBus}), {31'd0, 1'b1, 32'h100});
    Reset = 1'b1;
    step();
    chk_obs("mid_access_reset", sample(), mk_e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    Reset = 1'b0;
    ReadOK = 1'b1;
    step();
    chk("post_reset_grant_m0", 64'({ReadAssert, AddressBus}), {31'd0, 1'b1, 32'h100});
    step();
    chk("post_reset_ack", 64'({m0_ack, m1_ack, m0_err}), 64'b100);
    chk("post_reset_rdata", 64'(m0_rdata), 64'hBEEF);
    apply(s_off);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mm_bus_arbiter.md
Name: mm_bus_arbiter

Overview:
- Shares one memory-mapped peripheral port (AddressBus/DataReadBus/DataWriteBus/WriteAssert/ReadAssert/WriteOK/ReadOK) between two masters: M0 (CPU load/store unit) and M1 (debug/DMA engine).
- Round-robin arbitration; one transaction at a time; per-master request/ack handshake.
- Bounded wait on peripheral OK; on timeout, returns an error response.
- Sits between the core's memory controller and peripherals such as the GPIO block.

Parameters:
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width on both sides.
- TIMEOUT, 16, max cycles in ACCESS awaiting OK before error; legal 1..255.

Ports:
- CoreClock  input  1  sole clock, all logic on posedge.
- Reset  input  1  synchronous, active-high.
- m0_req  input  1  M0 transaction request, held until m0_ack.
- m0_write  input  1  1=write, 0=read.
- m0_addr  input  ADDR_W  M0 address.
- m0_wdata  input  DATA_W  M0 write data.
- m0_rdata  output  DATA_W  read data, valid when m0_ack=1.
- m0_ack  output  1  one-cycle completion pulse.
- m0_err  output  1  timeout flag, valid with m0_ack.
- m1_req, m1_write, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err: identical to M0.
- AddressBus  output  ADDR_W  to peripheral.
- DataWriteBus  output  DATA_W  to peripheral.
- DataReadBus  input  DATA_W  from peripheral, combinational on AddressBus.
- WriteAssert  output  1  write strobe.
- ReadAssert  output  1  read strobe.
- WriteOK  input  1  peripheral write accepted.
- ReadOK  input  1  peripheral read data valid.

Behaviour:
- Clock and reset: one clock (CoreClock); reset is synchronous and active-high (Reset).
- Reset values:
  - State IDLE; priority pointer favours M0.
  - All acks, errs, WriteAssert and ReadAssert are 0.
  - AddressBus, DataWriteBus, m0_rdata and m1_rdata are 0.
- FSM has three states:
  - IDLE:
    - If only one req is high, grant it.
    - If both are high, grant the master the pointer favours. The pointer then moves to the other master.
    - On grant, latch write/addr/wdata into internal registers and go to ACCESS. Timeout counter = 0.
  - ACCESS:
    - Drive AddressBus/DataWriteBus from the latched registers.
    - Assert WriteAssert (write) or ReadAssert (read) continuously. Never both.
    - If the matching OK=1 this cycle: capture DataReadBus into the granted master's rdata (reads only; writes leave rdata unchanged) and go to RESP.
    - Else, if counter == TIMEOUT-1: go to RESP with err=1 and rdata=0.
    - Else, increment the counter.
  - RESP:
    - Pulse the granted master's ack for exactly one cycle, with err as determined.
    - Strobes are 0.
    - Return to IDLE.
- Latency with a zero-wait peripheral (OK tied 1):
  - req high before edge N → ACCESS in cycle N+1 → ack in cycle N+2.
  - Minimum spacing between consecutive grants is 3 cycles.
- Request rules:
  - Masters must not change a request's payload before its ack.
  - Payload is latched at grant, so mid-transaction changes have no effect.
  - req still high in the cycle after ack is a new request.
- The non-granted master's req is ignored until IDLE; its ack and err stay 0.
- AddressBus and DataWriteBus hold their last values outside ACCESS (no toggling). Strobes are the only qualifiers.
- Reset asserted mid-ACCESS: strobes drop at that edge; no ack is issued; the pending transaction is discarded.
- Counter width is 8 bits, and it never wraps.

Decomposition:
- Shared package mm_bus_pkg:
  - State enum {IDLE, ACCESS, RESP}.
  - Master-index constants M0=0, M1=1.
  - Error read value (0).
- Natural sub-module: rr_arbiter2 (req[1:0], advance → grant one-hot, registered pointer).
- FSM and datapath latch stay in mm_bus_arbiter.

Test Plan:
- Single M0 read, addr 0x0000000C, DataReadBus=0x000002A5, ReadOK=1 → ReadAssert high 1 cycle, m0_ack 2 cycles after req, m0_rdata=0x000002A5, m0_err=0.
- M1 write, addr 0x4, wdata 0x3FF, WriteOK=1 → WriteAssert for 1 cycle with AddressBus=0x4, DataWriteBus=0x3FF; m1_ack pulses; m0_ack stays 0.
- Both req high continuously after reset → grant order M0, M1, M0, M1; acks spaced 3 cycles apart.
- Read with ReadOK held 0, TIMEOUT=16 → ReadAssert high exactly 16 cycles, then m0_ack=1, m0_err=1, m0_rdata=0.
- ReadOK delayed 5 cycles, then 1 → ack follows with err=0 and correct data; strobe held for 6 cycles.
- Reset pulsed during 3rd ACCESS cycle → strobes 0 next cycle, no ack; after reset, simultaneous reqs grant M0 first.
